control_unit: RTL and testbench

Multicycle control FSM sitting directly upstream of the register/instruction datapath. Consumes the 16-bit instruction produced by the instruction register and the ALU zero flag. Generates every datapath strobe: IR load, PC load/branch/flush, and register-file write. Also drives the ALU operation select and destination register address, and halts the machine on HLT.

---
 rtl/control_unit.sv | 137 +++++++++++++
 tb/tb_control_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXECUTE/WRITEBACK/HALT and decodes datapath strobes.
// Optional retired-instruction counter is built only when CU_RETIRE_CNT_EN is defined.
module control_unit #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] inst,
  input  logic        alu_zero,
  output logic        ir_ld,
  output logic        pc_ld,
  output logic        pc_branch,
  output logic        flush,
  output logic        mem_en,
  output logic        mem_wrt,
  output logic [3:0]  reg_out,
  output logic [7:0]  branch_addr,
  output logic [3:0]  alu_op,
  output logic        zflag,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] retired
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 16;

  localparam logic [OP_W-1:0] OP_CMP = 4'b1001;
  localparam logic [OP_W-1:0] OP_JMP = 4'b1010;
  localparam logic [OP_W-1:0] OP_JZ  = 4'b1011;
  localparam logic [OP_W-1:0] OP_LDI = 4'b1100;
  localparam logic [OP_W-1:0] OP_JNZ = 4'b1101;
  localparam logic [OP_W-1:0] OP_RSV = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  state_t state;

  logic [OP_W-1:0] opcode;
  logic            is_alu;
  logic            needs_wb;
  logic            taken;

  assign opcode   = inst[15:12];
  assign is_alu   = (opcode >= 4'b0001) && (opcode <= 4'b1000);
  assign needs_wb = is_alu || (opcode == OP_LDI);
  // Branch conditions use the flag as it stood before this EXECUTE cycle.
  assign taken    = (opcode == OP_JMP) ||
                    ((opcode == OP_JZ)  &&  zflag) ||
                    ((opcode == OP_JNZ) && !zflag);

  // State sequencing and architectural zero flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      zflag <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (run) state <= S_DECODE;
        S_DECODE: state <= (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
        S_EXECUTE: begin
          if (is_alu || (opcode == OP_CMP)) zflag <= alu_zero;
          if (needs_wb)                                   state <= S_WRITEBACK;
          else if ((opcode == OP_RSV) && HALT_ON_ILLEGAL) state <= S_HALT;
          else                                            state <= S_FETCH;
        end
        S_WRITEBACK: state <= S_FETCH;
        S_HALT:      state <= S_HALT;
        default:     state <= S_FETCH;
      endcase
    end
  end

`ifdef CU_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  assign retire = (state == S_WRITEBACK) ||
                  ((state == S_EXECUTE) && !needs_wb &&
                   !((opcode == OP_RSV) && HALT_ON_ILLEGAL));

  // Counts returns to FETCH; wraps naturally at the counter width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) retired_q <= '0;
    else if (retire) retired_q <= retired_q + CNT_W'(1);
  end

  assign retired = retired_q;
`else
  assign retired = 16'h0000;
`endif

  assign reg_out     = inst[11:8];
  assign branch_addr = inst[7:0];

  // Strobe decode from the state register, inst and zflag (run only in FETCH).
  always_comb begin
    ir_ld     = 1'b0;
    pc_ld     = 1'b0;
    pc_branch = 1'b0;
    flush     = 1'b0;
    mem_en    = 1'b0;
    mem_wrt   = 1'b0;
    alu_op    = 4'b0000;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_FETCH:  ir_ld = run & rst;
      S_DECODE: pc_ld = 1'b1;
      S_EXECUTE: begin
        alu_op  = opcode;
        illegal = (opcode == OP_RSV);
        if (taken) begin
          pc_ld     = 1'b1;
          pc_branch = 1'b1;
          flush     = 1'b1;
        end
      end
      S_WRITEBACK: begin
        alu_op  = opcode;
        mem_en  = 1'b1;
        mem_wrt = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level model queues the expected
// per-cycle output bundle; a monitor pops and compares on every falling edge.
module tb_control_unit;

  typedef struct packed {
    logic        ir_ld;
    logic        pc_ld;
    logic        pc_branch;
    logic        flush;
    logic        mem_en;
    logic        mem_wrt;
    logic [3:0]  reg_out;
    logic [7:0]  branch_addr;
    logic [3:0]  alu_op;
    logic        zflag;
    logic        halted;
    logic        illegal;
    logic [15:0] retired;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] inst;
  logic        alu_zero;
  logic        ir_ld, pc_ld, pc_branch, flush, mem_en, mem_wrt;
  logic [3:0]  reg_out, alu_op;
  logic [7:0]  branch_addr;
  logic        zflag, halted, illegal;
  logic [15:0] retired;

  control_unit dut (
    .clk(clk), .rst(rst), .run(run), .inst(inst), .alu_zero(alu_zero),
    .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_branch(pc_branch), .flush(flush),
    .mem_en(mem_en), .mem_wrt(mem_wrt), .reg_out(reg_out),
    .branch_addr(branch_addr), .alu_op(alu_op), .zflag(zflag),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  obs_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic        m_z;
  logic [15:0] m_ret;
  logic [15:0] cur_inst;

  function automatic obs_t sample();
    obs_t a;
    a = {ir_ld, pc_ld, pc_branch, flush, mem_en, mem_wrt, reg_out,
         branch_addr, alu_op, zflag, halted, illegal, retired};
    return a;
  endfunction

  function automatic obs_t base_rec();
    obs_t r;
    r = '0;
    r.reg_out     = cur_inst[11:8];
    r.branch_addr = cur_inst[7:0];
    r.zflag       = m_z;
    r.retired     = m_ret;
    return r;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every falling edge with a pending expectation is one comparison.
  always @(negedge clk) begin
    cyc++;
    if (q.size() > 0) check("cycle", sample(), q.pop_front());
  end

  // Instruction-level reference: queue the expected cycles, then let them elapse.
  task automatic issue(input logic [15:0] i, input logic az);
    obs_t r;
    int   n;
    logic [3:0] op;
    logic tk;
    op = i[15:12];
    inst = i; alu_zero = az; run = 1'b1; cur_inst = i;
    r = base_rec(); r.ir_ld = 1'b1; q.push_back(r);
    r = base_rec(); r.pc_ld = 1'b1; q.push_back(r);
    n = 2;
    if (op == 4'hF) begin
      repeat (12) begin r = base_rec(); r.halted = 1'b1; q.push_back(r); end
      n += 12;
    end else begin
      tk = (op == 4'hA) || (op == 4'hB && m_z) || (op == 4'hD && !m_z);
      r = base_rec(); r.alu_op = op; r.illegal = (op == 4'hE);
      r.pc_ld = tk; r.pc_branch = tk; r.flush = tk;
      q.push_back(r); n++;
      if (op >= 4'h1 && op <= 4'h9) m_z = az;
      if ((op >= 4'h1 && op <= 4'h8) || op == 4'hC) begin
        r = base_rec(); r.alu_op = op; r.mem_en = 1'b1; r.mem_wrt = 1'b1;
        q.push_back(r); n++;
      end
`ifdef CU_RETIRE_CNT_EN
      m_ret = m_ret + 16'd1;
`endif
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stall(input int k);
    obs_t r;
    run = 1'b0;
    inst = 16'($urandom);
    cur_inst = inst;
    for (int j = 0; j < k; j++) begin r = base_rec(); q.push_back(r); end
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string name);
    obs_t r;
    rst = 1'b0;
    m_z = 1'b0; m_ret = 16'h0000; cur_inst = inst;
    #1;
    r = base_rec();
    check(name, sample(), r);
  endtask

  initial begin
    logic [15:0] ri;
    m_z = 1'b0; m_ret = '0;
    run = 1'b1; inst = 16'h1321; alu_zero = 1'b0; cur_inst = inst;
    reset_check("reset_run_high");
    run = 1'b0;
    #11 rst = 1'b1;
    @(posedge clk); #1;

    issue(16'h1321, 1'b0);
    issue(16'hC5A7, 1'b1);
    issue(16'h9000, 1'b1);
    issue(16'hB040, 1'b0);
    issue(16'h9000, 1'b1);
    issue(16'hD040, 1'b1);
    issue(16'h9000, 1'b0);
    issue(16'hB012, 1'b1);
    issue(16'hD034, 1'b1);
    issue(16'hA0FF, 1'b0);
    issue(16'hE123, 1'b1);
    issue(16'h0000, 1'b1);
    stall(5);
    issue(16'h1321, 1'b1);
    issue(16'h2456, 1'b0);
    issue(16'h3789, 1'b1);
    stall(1);

    for (int k = 0; k < 120; k++) begin
      ri = 16'($urandom);
      ri[15:12] = 4'($urandom_range(0, 14));
      if ($urandom_range(0, 9) == 0) stall(int'($urandom_range(1, 3)));
      issue(ri, 1'($urandom));
    end

    issue(16'hF000, 1'b0);
    #1;
    reset_check("reset_from_halt");
    run = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    issue(16'h1A21, 1'b1);
    issue(16'hB077, 1'b0);

    for (int k = 0; k < 50 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d expected cycles left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
